// File: rtl/seq_scan_ctrl.sv
// Streams valid/ready words one bit per clock through a masked, overlapping pattern detector.
// Optional macro SCAN_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [PAT_W-1:0]  cfg_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done
);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d, mask_q, mask_d, hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              match_q, match_d, done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              bit_in;
  logic [PAT_W-1:0]  hist_nx;
  logic [FILL_W-1:0] fill_nx;

  always_comb begin
`ifdef SCAN_LSB_FIRST_EN
    bit_in = word_q[IDX_TOP - idx_q];
`else
    bit_in = word_q[idx_q];
`endif
    hist_nx = {hist_q[PAT_W-2:0], bit_in};
    fill_nx = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      // Abort beats start and any in-flight shift; the count is kept for software.
      state_d = S_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          pat_d   = cfg_pattern;
          mask_d  = cfg_mask;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_TOP;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          hist_d = hist_nx;
          fill_d = fill_nx;
          if (fill_nx == FILL_MAX && ((hist_nx ^ pat_q) & mask_q) == '0) begin
            match_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
          if (idx_q == '0) state_d = last_q ? S_DONE : S_WAIT;
          else             idx_d   = idx_q - 1'b1;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      mask_q  <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
endmodule
